// File: rtl/seq_pkg.sv
// Shared types and constants for the pattern-sequence store and its playback reader.
package seq_pkg;

    localparam int SEQ_W     = 8;
    localparam int SEQ_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHOW,
        GAP
    } play_state_t;

    typedef logic [SEQ_W-1:0] pattern_t;

endpackage

// File: rtl/seq_tick_timer.sv
// Loadable down-counter with a zero flag; counts toward zero and then parks there.
// Shared by playback timing and the player input-timeout logic.
module seq_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_playback.sv
// Replays a stored sequence of LED patterns: each entry is lit for an on-time, then blanked.
// Optional macro SEQ_PLAYBACK_SPEEDUP_EN adds a LEVEL input that shortens both durations.
module seq_playback
    import seq_pkg::*;
#(
    parameter int          DEPTH      = SEQ_DEPTH,
    parameter int unsigned ON_CYCLES  = 50_000_000,
    parameter int unsigned OFF_CYCLES = 25_000_000,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [AW:0]   LEN,
`ifdef SEQ_PLAYBACK_SPEEDUP_EN
    input  logic [1:0]    LEVEL,
`endif
    input  logic          ABORT,
    output logic          RD_EN,
    output logic [AW-1:0] RD_ADDR,
    input  logic [7:0]    RD_DATA,
    output logic [7:0]    LEDS,
    output logic          BUSY,
    output logic          DONE,
    output logic [2:0]    DBG_STATE
);

    localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int          TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    play_state_t     state_q;
    logic [AW-1:0]   idx_q;
    logic [AW:0]     len_q;
    pattern_t        leds_q;
    logic            rd_en_q;
    logic [AW-1:0]   rd_addr_q;
    logic            busy_q;
    logic            done_q;

    logic            tmr_load;
    logic            tmr_zero;
    logic [TW-1:0]   tmr_load_val;
    logic [TW-1:0]   on_load;
    logic [TW-1:0]   off_load;
    logic            last_entry;

`ifdef SEQ_PLAYBACK_SPEEDUP_EN
    logic [1:0] level_q;

    // Shifted duration minus one, never below a single cycle.
    function automatic logic [TW-1:0] scaled_load(input int unsigned cycles, input logic [1:0] lvl);
        int unsigned v;
        v = cycles >> lvl;
        if (v == 0) v = 1;
        return TW'(v - 1);
    endfunction

    assign on_load  = scaled_load(ON_CYCLES, level_q);
    assign off_load = scaled_load(OFF_CYCLES, level_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_q <= 2'd0;
        end else if (state_q == IDLE && START && !done_q && LEN != '0) begin
            level_q <= LEVEL;
        end
    end
`else
    assign on_load  = TW'(ON_CYCLES - 1);
    assign off_load = TW'(OFF_CYCLES - 1);
`endif

    // The timer is reloaded on entry to SHOW (from LOAD) and on entry to GAP.
    assign tmr_load     = (state_q == LOAD) || (state_q == SHOW && tmr_zero);
    assign tmr_load_val = (state_q == LOAD) ? on_load : off_load;
    assign last_entry   = ({1'b0, idx_q} == (len_q - 1'b1));

    seq_tick_timer #(.W(TW)) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            leds_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ABORT && state_q != IDLE) begin
                state_q <= IDLE;
                leds_q  <= '0;
                rd_en_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        // A START coinciding with the DONE pulse is dropped.
                        if (START && !done_q) begin
                            if (LEN == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                len_q     <= (LEN > DEPTH_L) ? DEPTH_L : LEN;
                                idx_q     <= '0;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        rd_en_q <= 1'b0;
                        state_q <= LOAD;
                    end
                    LOAD: begin
                        leds_q  <= RD_DATA;
                        state_q <= SHOW;
                    end
                    SHOW: begin
                        if (tmr_zero) begin
                            leds_q  <= '0;
                            state_q <= GAP;
                        end
                    end
                    GAP: begin
                        if (tmr_zero) begin
                            if (last_entry) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                idx_q     <= idx_q + 1'b1;
                                rd_addr_q <= idx_q + 1'b1;
                                rd_en_q   <= 1'b1;
                                state_q   <= FETCH;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign RD_EN     = rd_en_q;
    assign RD_ADDR   = rd_addr_q;
    assign LEDS      = leds_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_seq_playback.sv
// Directed bench for seq_playback with a synchronous storage model and LED/address scoreboards.
module tb_seq_playback;
  import seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int ON    = 4;
  localparam int OFF   = 2;
  localparam int AW    = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [AW:0]   LEN = '0;
  logic          RD_EN;
  logic [AW-1:0] RD_ADDR;
  logic [7:0]    RD_DATA = 8'h00;
  logic [7:0]    LEDS;
  logic          BUSY;
  logic          DONE;
  logic [2:0]    DBG_STATE;
`ifdef SEQ_PLAYBACK_SPEEDUP_EN
  logic [1:0]    LEVEL = 2'd0;
`endif

  pattern_t      mem [DEPTH];
  logic [7:0]    exp_led_q[$];
  logic [AW-1:0] exp_addr_q[$];

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  seq_playback #(
    .DEPTH      (DEPTH),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .LEN       (LEN),
`ifdef SEQ_PLAYBACK_SPEEDUP_EN
    .LEVEL     (LEVEL),
`endif
    .ABORT     (ABORT),
    .RD_EN     (RD_EN),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA),
    .LEDS      (LEDS),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DBG_STATE (DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // storage model: one-cycle read latency
  always @(posedge CLK) begin
    if (RD_EN) RD_DATA <= mem[RD_ADDR];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every busy cycle pops one LED value, every read pops one address
  always @(negedge CLK) begin
    if (!RST) begin
      if (DONE === 1'b1) done_cnt++;
      if (BUSY === 1'b1) begin
        if (exp_led_q.size() == 0) check("busy_unexpected", BUSY, 0);
        else check("leds", LEDS, exp_led_q.pop_front());
      end
      if (RD_EN === 1'b1) begin
        if (exp_addr_q.size() == 0) check("rd_unexpected", RD_EN, 0);
        else check("rd_addr", RD_ADDR, exp_addr_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic push_step(input int addr);
    exp_addr_q.push_back(AW'(addr));
    exp_led_q.push_back(8'h00);
    exp_led_q.push_back(8'h00);
    for (int k = 0; k < ON; k++) exp_led_q.push_back(mem[addr]);
    for (int k = 0; k < OFF; k++) exp_led_q.push_back(8'h00);
  endtask

  task automatic start(input int n);
    @(negedge CLK);
    START = 1'b1;
    LEN = (AW+1)'(n);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (DONE !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, DONE, 1);
    exp_done++;
    @(negedge CLK);
    check({tag, "_pulse_end"}, DONE, 0);
    check({tag, "_busy_end"}, BUSY, 0);
    check({tag, "_done_count"}, done_cnt, exp_done);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_led_q"}, exp_led_q.size(), 0);
    check({tag, "_addr_q"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    mem[0] = 8'h01;
    mem[1] = 8'h80;
    mem[2] = 8'h3C;
    for (int i = 3; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);

    // reset state
    #1 RST = 1'b1;
    #1;
    check("rst_leds", LEDS, 0);
    check("rst_rd_en", RD_EN, 0);
    check("rst_rd_addr", RD_ADDR, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_state", DBG_STATE, 32'(IDLE));
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // three-entry playback
    for (int i = 0; i < 3; i++) push_step(i);
    start(3);
    wait_done(100, "len3");
    check_drained("len3");

    // zero length: immediate DONE, no read, never busy
    start(0);
    check("len0_done", DONE, 1);
    check("len0_busy", BUSY, 0);
    check("len0_rd_en", RD_EN, 0);
    exp_done++;
    @(negedge CLK);
    check("len0_pulse_end", DONE, 0);
    check("len0_done_count", done_cnt, exp_done);

    // length above DEPTH clamps to 16 entries
    for (int i = 0; i < DEPTH; i++) push_step(i);
    start(20);
    wait_done(300, "len20");
    check_drained("len20");

    // abort during second SHOW
    push_step(0);
    exp_addr_q.push_back(AW'(1));
    exp_led_q.push_back(8'h00);
    exp_led_q.push_back(8'h00);
    exp_led_q.push_back(mem[1]);
    exp_led_q.push_back(mem[1]);
    start(3);
    repeat (11) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_leds", LEDS, 0);
    check("abort_busy", BUSY, 0);
    check("abort_rd_en", RD_EN, 0);
    check("abort_done", DONE, 1);
    exp_done++;
    @(negedge CLK);
    check("abort_pulse_end", DONE, 0);
    check("abort_done_count", done_cnt, exp_done);
    check_drained("abort");

    push_step(0);
    start(1);
    wait_done(100, "after_abort");
    check_drained("after_abort");

    // START during SHOW is ignored
    for (int i = 0; i < 3; i++) push_step(i);
    start(3);
    repeat (3) @(negedge CLK);
    START = 1'b1;
    LEN = (AW+1)'(1);
    @(negedge CLK);
    START = 1'b0;
    wait_done(100, "start_busy");
    check_drained("start_busy");

    // async reset in the first GAP, between clock edges
    push_step(0);
    void'(exp_led_q.pop_back());
    start(3);
    repeat (6) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("midrst_leds", LEDS, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_rd_en", RD_EN, 0);
    check("midrst_done", DONE, 0);
    check("midrst_state", DBG_STATE, 32'(IDLE));
    repeat (3) @(negedge CLK);
    check("midrst_no_done", DONE, 0);
    check("midrst_done_count", done_cnt, exp_done);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_after_busy", BUSY, 0);
    check_drained("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_playback.md
Name: seq_playback

Overview:
- Reader side of the pattern-sequence store: replays a stored sequence of 8-bit LED patterns to the board LEDs.
- Each step is shown for a fixed on-time, then a blank gap.
- Fetches entries over a synchronous read port (1-cycle read latency) from the sequence storage RAM.
- Sits between the game controller (START/LEN/DONE) and the LED driver. The player watches the replay, then re-enters the sequence.

Parameters:
- DEPTH, 16, max sequence entries; address width AW = $clog2(DEPTH).
- ON_CYCLES, 50_000_000, clock cycles each pattern is lit (>=1).
- OFF_CYCLES, 25_000_000, clock cycles LEDs are blank after each pattern (>=1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request to begin playback; sampled only in IDLE.
- LEN  in  AW+1  number of entries to play; sampled with START.
- ABORT  in  1  stop playback immediately.
- RD_EN  out  1  read strobe to storage.
- RD_ADDR  out  AW  read address.
- RD_DATA  in  8  storage data, valid the cycle after RD_EN.
- LEDS  out  8  displayed pattern.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when playback completes or aborts.

Behaviour:
- Reset (async assert; release synchronous to CLK): state=IDLE; LEDS=0, RD_EN=0, RD_ADDR=0, BUSY=0, DONE=0; internal idx, len, timer cleared.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, SHOW, GAP.
- IDLE:
  - START=1 and LEN>0: latch len=min(LEN,DEPTH), idx=0, go FETCH.
  - START=1 and LEN=0: pulse DONE next cycle; stay IDLE; no read issued.
- FETCH (1 cycle): RD_EN=1, RD_ADDR=idx; go LOAD.
- LOAD (1 cycle): RD_EN=0; LEDS<=RD_DATA at end of cycle; timer<=ON_CYCLES-1; go SHOW.
- SHOW:
  - LEDS holds the pattern for exactly ON_CYCLES cycles.
  - At timer==0: LEDS<=0, timer<=OFF_CYCLES-1, go GAP.
- GAP:
  - LEDS=0 for exactly OFF_CYCLES cycles.
  - At timer==0: if idx==len-1, pulse DONE and go IDLE; else idx<=idx+1, go FETCH.
- Step period: ON_CYCLES+OFF_CYCLES+2 cycles. First pattern appears 3 cycles after the START cycle.
- Identical consecutive patterns remain distinguishable because of the gap.
- ABORT (any non-IDLE state): next cycle state=IDLE, LEDS=0, RD_EN=0, DONE pulses once. ABORT in IDLE is ignored.
- ABORT and START in the same IDLE cycle: START wins.
- START while BUSY: ignored; LEN is not re-sampled.
- DONE and START on the same cycle (IDLE entered with DONE): START is accepted on the following cycle only.
- RD_DATA is captured only in LOAD; other cycles are don't-care.
- Reset mid-playback: immediate return to the reset values above; no DONE pulse.

Optional Feature:
- Macro SEQ_PLAYBACK_SPEEDUP_EN.
- Defined: extra input LEVEL [1:0], sampled with START. Effective on/off times are ON_CYCLES>>LEVEL and OFF_CYCLES>>LEVEL, each floored at 1.
- Undefined: no LEVEL port; fixed durations.

Decomposition:
- Shared package seq_pkg holds:
  - SEQ_W=8
  - SEQ_DEPTH=16
  - typedef enum logic [2:0] play_state_t {IDLE, FETCH, LOAD, SHOW, GAP}
  - typedef logic [SEQ_W-1:0] pattern_t
- Natural sub-module: seq_tick_timer, a loadable down-counter with a zero flag, also reusable by the input-timeout logic.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2; storage model preloaded 0x01, 0x80, 0x3C):
- START, LEN=3:
  - RD_ADDR sequence 0, 1, 2.
  - LEDS = 0x01 x4, 0x00 x2, 0x80 x4, 0x00 x2, 0x3C x4, 0x00 x2.
  - Single DONE pulse after the final gap; BUSY high throughout.
- START, LEN=0: DONE pulses next cycle; RD_EN never asserts; BUSY stays 0.
- START, LEN=20 with DEPTH=16: exactly 16 reads (addr 0..15), then DONE.
- ABORT during 2nd SHOW: next cycle LEDS=0, BUSY=0, one DONE pulse. A later START, LEN=1 plays 0x01 correctly.
- START pulsed during SHOW with LEN=1: ignored; original LEN=3 playback completes unchanged.
- RST asserted mid-GAP without a clock edge: outputs zero immediately; no DONE. With SEQ_PLAYBACK_SPEEDUP_EN, LEVEL=1 gives a 2-cycle on-time and 1-cycle gap.
